// File: rtl/ahb_ram_slave.sv
// AHB-Lite responder driving one byte-laned synchronous RAM bank; RD_LAT read wait states.
// Define AHB_RAM_ALIGN_CHECK_EN to enable the size/alignment check with a two-cycle ERROR response.
module ahb_ram_slave #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic              hmastlock,
  input  logic [3:0]        hprot,
  input  logic [1:0]        htrans,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rwn,
  output logic [3:0]        ram_wben,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR, RD_WAIT, RD_DONE
`ifdef AHB_RAM_ALIGN_CHECK_EN
    , ERR1, ERR2
`endif
  } state_t;

  localparam logic [1:0] LAST = 2'(RD_LAT - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       accept;
  logic [3:0] lane_wben;
  logic       unused_bits;

  assign accept      = hsel & hready & htrans[1] & hreadyout;
  assign unused_bits = ^{hburst, hmastlock, hprot, htrans[0], haddr[31:ADDR_W+2]};

`ifdef AHB_RAM_ALIGN_CHECK_EN
  logic bad;
  assign bad = (hsize > 3'd2) ||
               ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) ||
               ((hsize == 3'd1) && haddr[0]);
`endif

  // Low address bits below the transfer size are ignored; oversize is a word.
  always_comb begin
    lane_wben = 4'b0000;
    case (hsize)
      3'd0:    lane_wben = ~(4'b0001 << haddr[1:0]);
      3'd1:    lane_wben = haddr[1] ? 4'b0011 : 4'b1100;
      default: lane_wben = 4'b0000;
    endcase
  end

  // Write data passes straight through in the data phase; lane strobes and address are registered.
  assign ram_wdata = ram_rwn ? '0 : hwdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
      ram_addr  <= '0;
      ram_rwn   <= 1'b1;
      ram_wben  <= '1;
    end else begin
      ram_rwn  <= 1'b1;
      ram_wben <= '1;
      case (state)
        RD_WAIT: begin
          if (cnt == LAST) begin
            state     <= RD_DONE;
            hreadyout <= 1'b1;
            hrdata    <= ram_rdata;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
`ifdef AHB_RAM_ALIGN_CHECK_EN
        ERR1: begin
          state     <= ERR2;
          hreadyout <= 1'b1;
        end
`endif
        default: begin
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          if (accept) begin
            ram_addr <= haddr[ADDR_W+1:2];
            cnt      <= '0;
`ifdef AHB_RAM_ALIGN_CHECK_EN
            if (bad) begin
              state     <= ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
            end else
`endif
            if (hwrite) begin
              state    <= WR;
              ram_rwn  <= 1'b0;
              ram_wben <= lane_wben;
            end else begin
              state     <= RD_WAIT;
              hreadyout <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave: transaction-level model compared every cycle, plus literal checks.
// Works with or without AHB_RAM_ALIGN_CHECK_EN defined.
module tb_ahb_ram_slave;
  localparam int ADDR_W = 14;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              hsel = 1'b0;
  logic [31:0]       haddr = '0;
  logic              hwrite = 1'b0;
  logic [2:0]        hsize = 3'd0;
  logic [2:0]        hburst = 3'd0;
  logic              hmastlock = 1'b0;
  logic [3:0]        hprot = 4'd0;
  logic [1:0]        htrans = 2'b00;
  logic [31:0]       hwdata = '0;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [31:0]       hrdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rwn;
  logic [3:0]        ram_wben;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] pend = '0;

  assign hready = hreadyout;

  ahb_ram_slave #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
    .htrans(htrans), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .ram_addr(ram_addr), .ram_rwn(ram_rwn),
    .ram_wben(ram_wben), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM bank with a two-cycle read: one address register then array lookup.
  logic [31:0]       ram [1<<ADDR_W];
  logic [ADDR_W-1:0] addr_q;
  always @(posedge clk) begin
    addr_q <= ram_addr;
    if (!ram_rwn)
      for (int i = 0; i < 4; i++)
        if (!ram_wben[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
  end
  assign ram_rdata = ram[addr_q];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Lanes covered by the naturally aligned block of the transfer size containing the address.
  function automatic logic [3:0] lanes_of(input logic [2:0] size, input logic [1:0] a);
    int bytes;
    int base;
    bytes = (size >= 3'd2) ? 4 : (1 << size);
    base  = (int'(a) / bytes) * bytes;
    lanes_of = 4'hF;
    for (int i = 0; i < 4; i++)
      if (i >= base && i < base + bytes) lanes_of[i] = 1'b0;
  endfunction

  function automatic logic is_err(input logic [2:0] size, input logic [1:0] a);
`ifdef AHB_RAM_ALIGN_CHECK_EN
    return (size > 3'd2) || (size == 3'd2 && a != 2'b00) || (size == 3'd1 && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  typedef enum {P_NONE, P_WR, P_RD, P_ERR} phase_t;
  logic [31:0] mmem [1<<ADDR_W];

  initial begin : compare
    phase_t            ph;
    int                left;
    logic [ADDR_W-1:0] ph_word;
    logic [3:0]        ph_lanes;
    logic [31:0]       exp_rd;
    logic              er, eresp, erwn;
    logic [3:0]        ewb;
    ph = P_NONE; left = 0; exp_rd = '0; ph_word = '0; ph_lanes = 4'hF;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_hreadyout", 32'(hreadyout), 32'd1);
        check("rst_hresp", 32'(hresp), 32'd0);
        check("rst_hrdata", hrdata, 32'd0);
        check("rst_ram_rwn", 32'(ram_rwn), 32'd1);
        check("rst_ram_wben", 32'(ram_wben), 32'hF);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        ph = P_NONE; left = 0; exp_rd = '0;
      end else begin
        er = 1'b1; eresp = 1'b0; erwn = 1'b1; ewb = 4'hF;
        case (ph)
          P_WR: begin
            erwn = 1'b0; ewb = ph_lanes;
            check("wr_ram_addr", 32'(ram_addr), 32'(ph_word));
            check("wr_ram_wdata", ram_wdata, hwdata);
            for (int i = 0; i < 4; i++)
              if (!ph_lanes[i]) mmem[ph_word][8*i +: 8] = hwdata[8*i +: 8];
          end
          P_RD: begin
            if (left > 0) begin
              er = 1'b0;
              check("rd_ram_addr", 32'(ram_addr), 32'(ph_word));
              left--;
            end else begin
              exp_rd = mmem[ph_word];
            end
          end
          P_ERR: begin
            eresp = 1'b1;
            if (left > 0) begin er = 1'b0; left--; end
          end
          default: ;
        endcase
        check("hreadyout", 32'(hreadyout), 32'(er));
        check("hresp", 32'(hresp), 32'(eresp));
        check("ram_rwn", 32'(ram_rwn), 32'(erwn));
        check("ram_wben", 32'(ram_wben), 32'(ewb));
        check("hrdata", hrdata, exp_rd);
        if (er) begin
          if (hsel && htrans[1]) begin
            ph_word  = haddr[ADDR_W+1:2];
            ph_lanes = lanes_of(hsize, haddr[1:0]);
            if (is_err(hsize, haddr[1:0])) begin ph = P_ERR; left = 1; end
            else if (hwrite) ph = P_WR;
            else begin ph = P_RD; left = RD_LAT; end
          end else begin
            ph = P_NONE;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (hreadyout) break;
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL ready_timeout: hreadyout still %b after %0d cycles, expected 1", hreadyout, n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hwdata = pend;
    wait_ready();
    pend = wr ? d : 32'h0;
  endtask

  task automatic idle(input int n, input logic sel, input logic [1:0] tr);
    hsel = sel; htrans = tr; hwdata = pend;
    repeat (n) wait_ready();
    pend = '0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: end of test not reached by %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    check("pin_lanes_half_hi", 32'(lanes_of(3'd1, 2'd2)), 32'h3);
    check("pin_lanes_byte3", 32'(lanes_of(3'd0, 2'd3)), 32'h7);
    check("pin_lanes_word", 32'(lanes_of(3'd2, 2'd1)), 32'h0);

    // word write then read back
    issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    idle(1, 1'b1, 2'b00);
    check("t1_rdata", hrdata, 32'hDEADBEEF);

    // back-to-back byte writes, lane-placed data
    issue(1'b1, 32'h20, 3'd0, 32'h00000011);
    issue(1'b1, 32'h21, 3'd0, 32'h00002200);
    issue(1'b1, 32'h22, 3'd0, 32'h00330000);
    issue(1'b1, 32'h23, 3'd0, 32'h44000000);
    issue(1'b0, 32'h20, 3'd2, 32'h0);
    idle(1, 1'b1, 2'b00);
    check("t2_rdata", hrdata, 32'h44332211);

    // halfword over a pre-written word
    issue(1'b1, 32'h30, 3'd2, 32'hFFFFFFFF);
    issue(1'b1, 32'h32, 3'd1, 32'hA5A50000);
    issue(1'b0, 32'h30, 3'd2, 32'h0);
    idle(1, 1'b1, 2'b00);
    check("t3_rdata", hrdata, 32'hA5A5FFFF);

    // misaligned accesses: ERROR with the check, low bits ignored without
    issue(1'b0, 32'h41, 3'd2, 32'h0);
    issue(1'b0, 32'h10, 3'd2, 32'h0);
    idle(1, 1'b1, 2'b00);
    check("t4_rdata", hrdata, 32'hDEADBEEF);
    issue(1'b1, 32'h24, 3'd2, 32'h01234567);
    issue(1'b1, 32'h25, 3'd1, 32'h0000BEEF);
    issue(1'b1, 32'h26, 3'd4, 32'h89ABCDEF);
    issue(1'b0, 32'h24, 3'd2, 32'h0);
    idle(1, 1'b1, 2'b00);
`ifdef AHB_RAM_ALIGN_CHECK_EN
    check("t4_err_rdata", hrdata, 32'h01234567);
`else
    check("t4_noerr_rdata", hrdata, 32'h89ABCDEF);
`endif

    // read then idle, busy and deselected cycles
    issue(1'b0, 32'h20, 3'd2, 32'h0);
    idle(2, 1'b1, 2'b00);
    idle(1, 1'b1, 2'b01);
    idle(2, 1'b0, 2'b10);
    check("t5_rdata", hrdata, 32'h44332211);

    // reset asserted during a read wait state
    issue(1'b0, 32'h20, 3'd2, 32'h0);
    hsel = 1'b0; htrans = 2'b00;
    #2 reset = 1'b0;
    #1;
    check("t6_hreadyout", 32'(hreadyout), 32'd1);
    check("t6_hrdata", hrdata, 32'd0);
    check("t6_ram_wben", 32'(ram_wben), 32'hF);
    check("t6_ram_rwn", 32'(ram_rwn), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    pend = '0;
    issue(1'b0, 32'h30, 3'd2, 32'h0);
    idle(2, 1'b1, 2'b00);
    check("t6_rdata", hrdata, 32'hA5A5FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_ram_slave.md
Name: ahb_ram_slave

Overview:
- AHB-Lite slave (responder) that terminates AHB transfers from the imem/dmem/SPI-loader masters and drives one byte-laned synchronous RAM bank.
- RAM side uses the existing bank convention: per-lane write occurs only when ram_rwn=0 AND ram_wben[i]=0.
- Sits between the Router's AHB ports and the iram/dram byte banks; the same block is instantiated once per bank.

Parameters:
- ADDR_W, 14, RAM word-address width; RAM word address = haddr[ADDR_W+1:2].
- RD_LAT, 1, RAM read latency in cycles (legal 1..3); equals the number of read wait states.

Ports:
- clk  in  1  system clock; all flops rising-edge.
- reset  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select from Router decode.
- haddr  in  32  AHB address.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  transfer size (0=byte, 1=half, 2=word).
- hburst  in  3  ignored; every beat is handled as SINGLE.
- hmastlock  in  1  ignored.
- hprot  in  4  ignored.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level ready (muxed hreadyout).
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  32  read data.
- ram_addr  out  ADDR_W  RAM word address.
- ram_rwn  out  1  0=write cycle.
- ram_wben  out  4  active-low byte write enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid RD_LAT cycles after ram_addr.

Behaviour:
- Reset values (async, reset=0):
  - State IDLE, hreadyout=1, hresp=0, hrdata=0.
  - ram_rwn=1, ram_wben=4'hF, ram_addr=0, ram_wdata=0.
- Transfer accept: on a clk edge with hsel & hready & htrans[1]. Capture word address, haddr[1:0], hsize and hwrite into data-phase registers.
- IDLE/BUSY or hsel=0: not accepted. Next data phase is OKAY with zero wait states and no RAM access.
- States: IDLE, WR, RD_WAIT, RD_DONE, ERR1, ERR2.
- WR (one cycle, zero wait):
  - ram_addr = latched word address; ram_rwn=0; ram_wdata=hwdata (combinational); hreadyout=1.
  - Lane enables, active-low:
    - byte: lane = addr[1:0].
    - half: addr[1]=0 -> 4'b1100, addr[1]=1 -> 4'b0011.
    - word: 4'b0000.
- RD_WAIT:
  - ram_addr = latched word address, ram_rwn=1, hreadyout=0.
  - A counter runs RD_LAT cycles, then the state moves to RD_DONE.
- RD_DONE:
  - hrdata <= ram_rdata, registered at the RD_WAIT exit edge; hreadyout=1.
  - The full 32-bit word is returned; the master selects lanes.
  - Total read latency = RD_LAT+1 data-phase cycles.
- hrdata holds its value until the next completed read.
- Pipelining: a new transfer can be accepted in any cycle with hreadyout=1 (IDLE, WR, RD_DONE, ERR2).
  - Write followed by read to the same address returns the new data: the write retires in its data phase, before the read drives the RAM.
- Error (only when AHB_RAM_ALIGN_CHECK_EN is defined). A request is an error if:
  - hsize>2, or
  - hsize=2 with haddr[1:0]!=0, or
  - hsize=1 with haddr[0]=1.
- Error response, no RAM access:
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
  - A transfer accepted in ERR2 proceeds normally.
- Outside WR: ram_rwn=1, ram_wben=4'hF.
- Reset mid-transfer: the in-flight transfer is abandoned, no RAM write is issued, and all outputs return to reset values immediately.
- Upper haddr bits above ADDR_W+1 are ignored; the Router decodes them.

Optional Feature:
- AHB_RAM_ALIGN_CHECK_EN defined: the alignment/size check and the two-cycle ERROR response above are active.
- Undefined:
  - hresp is tied 0 and ERR states are removed.
  - hsize>2 is treated as a word.
  - Misaligned half/word accesses ignore the low address bits below their size: half uses addr[1], word uses no low bits.

Test Plan:
1. Word write 0xDEADBEEF to 0x0000_0010, then word read from 0x10 -> ram_addr=4, ram_wben=0000 during WR; hrdata=0xDEADBEEF after RD_LAT+1 cycles with hresp=0.
2. Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23 back-to-back -> wben 1110, 1101, 1011, 0111, each zero-wait; word read of 0x20 returns 0x44332211.
3. Halfword write 0xA5A5 to 0x32 over a pre-written 0xFFFFFFFF at 0x30 -> wben=0011; read of 0x30 returns 0xA5A5FFFF.
4. With AHB_RAM_ALIGN_CHECK_EN, word read at 0x41 -> cycle 1 hreadyout=0 hresp=1, cycle 2 hreadyout=1 hresp=1, ram_rwn stays 1; the next NONSEQ read succeeds with OKAY.
5. NONSEQ read followed by htrans=IDLE and hsel=0 cycles -> no further RAM activity; hreadyout=1 and hresp=0 throughout the idle cycles.
6. Assert reset low during RD_WAIT -> hreadyout=1, hrdata=0, ram_wben=F immediately; after release, a word read of a prior-written address returns the correct data.
